// File: rtl/serial_bit_transmitter.sv
// serial_bit_transmitter
//   Parallel-to-serial source for a flip-flop based serial receiver. A word
//   accepted over DIN/DIN_VALID/DIN_READY is shifted out on SER_D, one bit
//   per DIV system clocks. SER_CLK rises in the middle of each bit period, so
//   a receiver D flip-flop clocked by SER_CLK sees each bit with DIV/2 cycles
//   of setup margin.
// Ports
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   DIN        word to transmit, sampled on handshake
//   DIN_VALID  DIN holds a valid word
//   DIN_READY  idle, a word can be accepted
//   SER_CLK    generated bit clock
//   SER_D      serial data, stable for the whole bit period
//   SER_FRAME  high while a word is being shifted out
//   DONE       one-cycle pulse after the last bit period
// All outputs are registered.
module serial_bit_transmitter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DIV       = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              SER_CLK,
  output logic              SER_D,
  output logic              SER_FRAME,
  output logic              DONE
);

  localparam int unsigned DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t            state, state_d;
  logic [DW-1:0]     div_cnt, div_d;
  logic [BW-1:0]     bit_cnt, bit_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic              ready_d, clk_d, d_d, frame_d, done_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      DIN_READY <= 1'b1;
      SER_CLK   <= 1'b0;
      SER_D     <= 1'b0;
      SER_FRAME <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_d;
      div_cnt   <= div_d;
      bit_cnt   <= bit_d;
      sh        <= sh_d;
      DIN_READY <= ready_d;
      SER_CLK   <= clk_d;
      SER_D     <= d_d;
      SER_FRAME <= frame_d;
      DONE      <= done_d;
    end
  end

  // Next-state logic computes the next value of every registered output, so
  // the outputs change on the same edge as the state they belong to.
  always_comb begin
    state_d = state;
    div_d   = div_cnt;
    bit_d   = bit_cnt;
    sh_d    = sh;
    ready_d = 1'b0;
    clk_d   = 1'b0;
    d_d     = 1'b0;
    frame_d = 1'b0;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (DIN_VALID) begin
          state_d = ST_SHIFT;
          sh_d    = DIN;
          div_d   = '0;
          bit_d   = '0;
          ready_d = 1'b0;
          frame_d = 1'b1;
          d_d     = MSB_FIRST ? DIN[DATA_W-1] : DIN[0];
        end
      end
      ST_SHIFT: begin
        frame_d = 1'b1;
        d_d     = SER_D;
        if (div_cnt == DIV_LAST) begin
          div_d = '0;
          if (bit_cnt == BIT_LAST) begin
            state_d = ST_DONE;
            bit_d   = '0;
            frame_d = 1'b0;
            done_d  = 1'b1;
            d_d     = 1'b0;
          end else begin
            bit_d = bit_cnt + 1'b1;
            if (MSB_FIRST) begin
              sh_d = sh << 1;
              d_d  = sh_d[DATA_W-1];
            end else begin
              sh_d = sh >> 1;
              d_d  = sh_d[0];
            end
          end
        end else begin
          div_d = div_cnt + 1'b1;
          clk_d = (div_d >= DIV_HALF);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

endmodule
